// File: rtl/addsub16_seq.sv
// rtl/addsub16_seq.sv - command sequencing, result capture and saturation around an external 16-bit add/sub datapath
module addsub16_seq #(
  parameter bit SAT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_ctrl,
  input  logic [15:0] add_sum,
  input  logic        add_cout,
  input  logic        add_ovf,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_sum,
  output logic        res_cout,
  output logic        res_ovf,
  output logic        sticky_ovf,
  input  logic        clr_sticky
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  logic        sub_q, sub_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] res_sum_q, res_sum_d;
  logic        res_cout_q, res_cout_d;
  logic        res_ovf_q, res_ovf_d;
  logic        sticky_q, sticky_d;
  logic [15:0] sat_sum;

  // Overflow direction follows the sign of operand A: a positive A can only overflow upward.
  always_comb begin
    sat_sum = add_sum;
    if (SAT && add_ovf) begin
      sat_sum = op_a_q[15] ? 16'h8000 : 16'h7FFF;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    sub_d      = sub_q;
    acc_d      = acc_q;
    res_sum_d  = res_sum_q;
    res_cout_d = res_cout_q;
    res_ovf_d  = res_ovf_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = EXEC;
          op_a_d  = cmd_op[1] ? acc_q : cmd_a;
          op_b_d  = cmd_b;
          sub_d   = cmd_op[0];
        end
      end
      EXEC: begin
        state_d    = HOLD;
        res_sum_d  = sat_sum;
        acc_d      = sat_sum;
        res_cout_d = add_cout;
        res_ovf_d  = add_ovf;
      end
      HOLD: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new overflow on the same edge as a clear keeps the flag set.
  always_comb begin
    sticky_d = sticky_q;
    if (clr_sticky) begin
      sticky_d = 1'b0;
    end
    if (state_q == EXEC && add_ovf) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_a_q     <= 16'h0000;
      op_b_q     <= 16'h0000;
      sub_q      <= 1'b0;
      acc_q      <= 16'h0000;
      res_sum_q  <= 16'h0000;
      res_cout_q <= 1'b0;
      res_ovf_q  <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      sub_q      <= sub_d;
      acc_q      <= acc_d;
      res_sum_q  <= res_sum_d;
      res_cout_q <= res_cout_d;
      res_ovf_q  <= res_ovf_d;
      sticky_q   <= sticky_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign res_valid  = (state_q == HOLD);
  assign add_a      = (state_q == EXEC) ? op_a_q : 16'h0000;
  assign add_b      = (state_q == EXEC) ? op_b_q : 16'h0000;
  assign add_ctrl   = (state_q == EXEC) ? sub_q : 1'b0;
  assign res_sum    = res_sum_q;
  assign res_cout   = res_cout_q;
  assign res_ovf    = res_ovf_q;
  assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_addsub16_seq.sv
// tb/tb_addsub16_seq.sv - directed scoreboard bench for addsub16_seq, wrap and saturate instances side by side
module tb_addsub16_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b;
  logic        res_ready;
  logic        clr_sticky;

  logic        w_cmd_ready, s_cmd_ready;
  logic [15:0] w_add_a, w_add_b, s_add_a, s_add_b;
  logic        w_add_ctrl, s_add_ctrl;
  logic [15:0] w_add_sum, s_add_sum;
  logic        w_add_cout, s_add_cout, w_add_ovf, s_add_ovf;
  logic        w_res_valid, s_res_valid;
  logic [15:0] w_res_sum, s_res_sum;
  logic        w_res_cout, s_res_cout, w_res_ovf, s_res_ovf;
  logic        w_sticky, s_sticky;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] sum_w;
    logic [15:0] sum_s;
    logic        cout;
    logic        ovf;
    logic        sticky;
  } exp_t;

  exp_t exp_q[$];
  logic sticky_m;

  always #5 clk = ~clk;

  // Reference adder: ctrl=1 computes a + ~b + 1.
  function automatic logic [17:0] adder(input logic [15:0] a, input logic [15:0] b, input logic ctrl);
    logic [15:0] bb;
    logic [16:0] r;
    bb = ctrl ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {16'h0000, ctrl};
    return {(a[15] == bb[15]) && (r[15] != a[15]), r[16], r[15:0]};
  endfunction

  always_comb {w_add_ovf, w_add_cout, w_add_sum} = adder(w_add_a, w_add_b, w_add_ctrl);
  always_comb {s_add_ovf, s_add_cout, s_add_sum} = adder(s_add_a, s_add_b, s_add_ctrl);

  addsub16_seq #(.SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(w_cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .add_a(w_add_a), .add_b(w_add_b), .add_ctrl(w_add_ctrl),
    .add_sum(w_add_sum), .add_cout(w_add_cout), .add_ovf(w_add_ovf), .res_valid(w_res_valid),
    .res_ready(res_ready), .res_sum(w_res_sum), .res_cout(w_res_cout), .res_ovf(w_res_ovf),
    .sticky_ovf(w_sticky), .clr_sticky(clr_sticky)
  );

  addsub16_seq #(.SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .add_a(s_add_a), .add_b(s_add_b), .add_ctrl(s_add_ctrl),
    .add_sum(s_add_sum), .add_cout(s_add_cout), .add_ovf(s_add_ovf), .res_valid(s_res_valid),
    .res_ready(res_ready), .res_sum(s_res_sum), .res_cout(s_res_cout), .res_ovf(s_res_ovf),
    .sticky_ovf(s_sticky), .clr_sticky(clr_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " w_cmd_ready"}, {31'd0, w_cmd_ready}, 32'd1);
    chk({tag, " s_cmd_ready"}, {31'd0, s_cmd_ready}, 32'd1);
    chk({tag, " w_res_valid"}, {31'd0, w_res_valid}, 32'd0);
    chk({tag, " s_res_valid"}, {31'd0, s_res_valid}, 32'd0);
  endtask

  // Issue one command, wait for its result, optionally stall the handshake, then compare against the scoreboard.
  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] sum_w, input logic [15:0] sum_s, input logic cout, input logic ovf,
                        input int stall);
    exp_t e;
    int   edges;
    logic [15:0] held;
    chk({tag, " ready_before"}, {31'd0, w_cmd_ready & s_cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    tick();
    cmd_valid = 1'b0;
    sticky_m  = sticky_m | ovf;
    e.sum_w = sum_w; e.sum_s = sum_s; e.cout = cout; e.ovf = ovf; e.sticky = sticky_m;
    exp_q.push_back(e);
    chk({tag, " exec_cmd_ready"}, {31'd0, w_cmd_ready}, 32'd0);
    chk({tag, " exec_ctrl"}, {31'd0, w_add_ctrl}, {31'd0, op[0]});
    if (!op[1]) chk({tag, " exec_add_a"}, {16'd0, w_add_a}, {16'd0, a});
    edges = 1;
    while (!w_res_valid && edges < 6) begin
      tick();
      edges++;
    end
    chk({tag, " latency"}, edges, 2);
    chk({tag, " hold_add_a"}, {16'd0, w_add_a}, 32'd0);
    held = w_res_sum;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, " stall_valid"}, {31'd0, w_res_valid & s_res_valid}, 32'd1);
      chk({tag, " stall_stable"}, {16'd0, w_res_sum}, {16'd0, held});
      chk({tag, " stall_cmd_ready"}, {31'd0, w_cmd_ready | s_cmd_ready}, 32'd0);
    end
    if (exp_q.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " w_sum"},    {16'd0, w_res_sum},  {16'd0, e.sum_w});
      chk({tag, " s_sum"},    {16'd0, s_res_sum},  {16'd0, e.sum_s});
      chk({tag, " w_cout"},   {31'd0, w_res_cout}, {31'd0, e.cout});
      chk({tag, " s_cout"},   {31'd0, s_res_cout}, {31'd0, e.cout});
      chk({tag, " w_ovf"},    {31'd0, w_res_ovf},  {31'd0, e.ovf});
      chk({tag, " s_ovf"},    {31'd0, s_res_ovf},  {31'd0, e.ovf});
      chk({tag, " w_sticky"}, {31'd0, w_sticky},   {31'd0, e.sticky});
      chk({tag, " s_sticky"}, {31'd0, s_sticky},   {31'd0, e.sticky});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, " after_valid"}, {31'd0, w_res_valid | s_res_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = 16'h0; cmd_b = 16'h0;
    res_ready = 1'b0; clr_sticky = 1'b0; sticky_m = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_idle("reset");
    chk("reset w_sum", {16'd0, w_res_sum}, 32'd0);
    chk("reset s_sum", {16'd0, s_res_sum}, 32'd0);
    chk("reset flags", {28'd0, w_res_cout, w_res_ovf, w_sticky, s_sticky}, 32'd0);
    chk("reset add", {w_add_a, w_add_b}, 32'd0);
    chk("reset ctrl", {31'd0, w_add_ctrl}, 32'd0);

    do_cmd("add_basic", 2'b00, 16'h1234, 16'h0001, 16'h1235, 16'h1235, 1'b0, 1'b0, 0);
    do_cmd("add_ovf",   2'b00, 16'h7FFF, 16'h0001, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 0);

    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    sticky_m = 1'b0;
    chk("clr w_sticky", {31'd0, w_sticky}, 32'd0);
    chk("clr s_sticky", {31'd0, s_sticky}, 32'd0);

    do_cmd("sub_basic", 2'b01, 16'h0005, 16'h0003, 16'h0002, 16'h0002, 1'b1, 1'b0, 0);
    do_cmd("sub_ovf",   2'b01, 16'h8000, 16'h0001, 16'h7FFF, 16'h8000, 1'b1, 1'b1, 0);

    do_cmd("chain_add",    2'b00, 16'h0010, 16'h0020, 16'h0030, 16'h0030, 1'b0, 1'b0, 0);
    do_cmd("chain_accsub", 2'b11, 16'hFFFF, 16'h0008, 16'h0028, 16'h0028, 1'b1, 1'b0, 0);
    do_cmd("chain_accadd", 2'b10, 16'hFFFF, 16'h0002, 16'h002A, 16'h002A, 1'b0, 1'b0, 0);

    // Backpressure: a second command is offered during the stall and must wait for the handshake.
    fork
      do_cmd("bp", 2'b00, 16'h0100, 16'h0200, 16'h0300, 16'h0300, 1'b0, 1'b0, 5);
      begin
        repeat (4) @(posedge clk);
        #2;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 16'h0001; cmd_b = 16'h0001;
      end
    join
    chk("bp pending_not_consumed", {31'd0, w_cmd_ready & s_cmd_ready}, 32'd1);
    do_cmd("bp_next", 2'b00, 16'h0001, 16'h0001, 16'h0002, 16'h0002, 1'b0, 1'b0, 0);

    // Reset while EXEC: the accepted ACCADD never delivers and acc returns to zero.
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_b = 16'h0005;
    tick();
    cmd_valid = 1'b0;
    chk("rst_exec in_exec", {31'd0, w_cmd_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sticky_m = 1'b0;
    chk_idle("rst_exec");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_exec no_valid", {31'd0, w_res_valid | s_res_valid}, 32'd0);
    end
    do_cmd("rst_accadd", 2'b10, 16'h1234, 16'h0001, 16'h0001, 16'h0001, 1'b0, 1'b0, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/addsub16_seq.md
# addsub16_seq

Sequencing and result-capture stage wrapped around the 16-bit add/sub datapath (`adder_16bit_s`). It accepts add/sub commands over a valid/ready handshake and drives the adder's operand and control inputs from registers. It captures the adder's SUM, C_out and overflow outputs, optionally saturates them, and presents the result downstream over a second valid/ready handshake. A 16-bit accumulator allows chained operations, and a sticky overflow flag latches any overflow.

## Interface
- `SAT`, default 0: 1 = saturate signed results on overflow; 0 = wrap.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: stage can accept a command.
- `cmd_op` in 2: 00 ADD a+b; 01 SUB a-b; 10 ACCADD acc+b; 11 ACCSUB acc-b.
- `cmd_a` in 16: operand A; ignored for ACC ops.
- `cmd_b` in 16: operand B.
- `add_a` out 16: to adder A.
- `add_b` out 16: to adder B.
- `add_ctrl` out 1: to adder Add_ctrl; 1 = subtract.
- `add_sum` in 16: from adder SUM; combinational, same cycle.
- `add_cout` in 1: from adder C_out.
- `add_ovf` in 1: from adder O.
- `res_valid` out 1: result present.
- `res_ready` in 1: downstream accepts the result.
- `res_sum` out 16: result, saturated when SAT=1.
- `res_cout` out 1: raw adder carry. For SUB, 1 means no borrow.
- `res_ovf` out 1: signed overflow of this operation.
- `sticky_ovf` out 1: OR of all `res_ovf` since reset or the last clear.
- `clr_sticky` in 1: clears `sticky_ovf`.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1.
  - EXEC: adder inputs held from the operand registers.
  - HOLD: `res_valid`=1.
- IDLE → EXEC on `cmd_valid`. The stage latches `op_a`, `op_b` and `sub` in the same edge.
  - `op_a` = `cmd_a` for op[1]=0, otherwise `acc`.
  - `sub` = `cmd_op[0]`.
- `add_a`/`add_b`/`add_ctrl` are driven from the operand registers in EXEC only, and are 0 in IDLE and HOLD.
- EXEC → HOLD unconditionally. On this edge the stage captures the adder outputs:
  - `res_cout` ← `add_cout`.
  - `res_ovf` ← `add_ovf`.
  - `res_sum` ← `add_sum` if SAT=0 or `add_ovf`=0. Otherwise 16'h7FFF when `op_a[15]`=0, or 16'h8000 when `op_a[15]`=1.
  - `acc` ← the value written to `res_sum`.
  - `sticky_ovf` ← 1 if `add_ovf`=1.
- HOLD → IDLE when `res_ready`=1. Outputs stay stable while `res_ready`=0.
- `cmd_ready`=0 in EXEC and HOLD. A command offered there is not consumed.
- Sticky flag: `clr_sticky` clears it. If `clr_sticky` and a set occur on the same edge, set wins (sticky=1).
- Arithmetic: 16-bit two's complement, performed entirely by the external adder. This block adds no arithmetic other than the saturation mux.
- `acc` wraps or saturates per SAT and is never cleared except by reset.

## Timing
- Reset (`rst` sampled high at an edge) sets:
  - State to IDLE.
  - `cmd_ready`=1 after reset; `res_valid`=0.
  - `res_sum`, `res_cout`, `res_ovf`, `sticky_ovf`, `acc` = 0.
  - `add_a`, `add_b`, `add_ctrl` = 0.
- Reset mid-EXEC or mid-HOLD aborts the operation: no result is delivered and `acc` becomes 0.
- Latency:
  - Command accepted at edge N.
  - Adder inputs valid during cycle N to N+1.
  - `res_valid`=1 after edge N+1.
- Throughput: at most one command per 3 cycles (IDLE, EXEC, HOLD with `res_ready`=1).
- The adder path must settle within one clock period. No multicycle path.
- `cmd_ready` and `res_valid` are registered-state decodes with no combinational path from `res_ready`.

## Test plan
- Reset then ADD 0x1234+0x0001: `res_sum`=0x1235, `cout`=0, `ovf`=0. `res_valid` rises 2 edges after acceptance.
- ADD 0x7FFF+0x0001:
  - SAT=0: `res_sum`=0x8000, `ovf`=1, `sticky`=1.
  - SAT=1: `res_sum`=0x7FFF.
- SUB 0x0005-0x0003: 0x0002, `cout`=1, `ovf`=0. SUB 0x8000-0x0001:
  - SAT=0: 0x7FFF, `ovf`=1.
  - SAT=1: 0x8000.
- Accumulator chain: ADD 0x0010+0x0020 (0x0030), then ACCSUB b=0x0008 gives 0x0028, then ACCADD b=0x0002 gives 0x002A.
- Backpressure and clear:
  - Hold `res_ready`=0 for 5 cycles: result stable, `cmd_ready`=0, the offered command is not consumed until after the handshake.
  - `clr_sticky` pulse with no overflow clears sticky.
- Assert `rst` during EXEC: next cycle in IDLE, `res_valid` never rises, `acc`=0. A subsequent ACCADD b=1 gives 0x0001.
